// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, short-frame padding,
// CRC-32 FCS append and inter-packet gap enforcement, one byte per clock.
module gmii_tx_framer #(
  parameter int MIN_FRAME      = 60,
  parameter int IPG_BYTES      = 12,
  parameter int PREAMBLE_BYTES = 7
) (
  input  logic       gmii_txc,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       gmii_txen,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       frame_done,
  output logic       tx_underrun
);

  localparam logic [10:0] MIN_COUNT      = 11'(MIN_FRAME);
  localparam logic [15:0] PRE_LAST       = 16'(PREAMBLE_BYTES - 1);
  localparam logic [15:0] IPG_LAST       = 16'(IPG_BYTES);
  localparam bit          SHORT_PREAMBLE = (PREAMBLE_BYTES <= 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IPG} state_t;

  state_t      state;
  logic [10:0] count;      // data+pad bytes sent, saturating
  logic [15:0] step;       // preamble / FCS byte / gap position
  logic [31:0] crc;
  logic        bad;        // underrun seen: send inverted FCS

  logic [7:0]  crc_data;
  logic [31:0] crc_upd;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;
  logic [10:0] count_inc;

  // Byte-wide reflected CRC-32 update (poly 0xEDB88320), unrolled by synthesis.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Pad bytes are zero; otherwise the CRC follows the accepted source byte.
  assign crc_data  = (state == PAD) ? 8'h00 : tx_data;
  assign crc_upd   = crc32_byte(crc, crc_data);
  assign count_inc = (count == 11'h7FF) ? count : count + 11'd1;
  assign fcs_word  = bad ? crc : ~crc;
  assign tx_ready  = (state == DATA);
  assign busy      = (state != IDLE);

  // Select the FCS byte for the current position, least significant first.
  always_comb begin
    fcs_byte = fcs_word[7:0];
    case (step[1:0])
      2'd1:    fcs_byte = fcs_word[15:8];
      2'd2:    fcs_byte = fcs_word[23:16];
      2'd3:    fcs_byte = fcs_word[31:24];
      default: fcs_byte = fcs_word[7:0];
    endcase
  end

  // Framing state machine with registered GMII outputs and status pulses.
  always_ff @(posedge gmii_txc or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= 11'd0;
      step        <= 16'd0;
      crc         <= 32'hFFFFFFFF;
      bad         <= 1'b0;
      gmii_txen   <= 1'b0;
      gmii_txd    <= 8'h00;
      frame_done  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      tx_underrun <= 1'b0;
      case (state)
        IDLE: begin
          gmii_txen <= 1'b0;
          gmii_txd  <= 8'h00;
          crc       <= 32'hFFFFFFFF;
          count     <= 11'd0;
          bad       <= 1'b0;
          step      <= 16'd1;
          if (tx_valid) begin
            // First preamble byte goes out on this edge.
            gmii_txen <= 1'b1;
            gmii_txd  <= 8'h55;
            state     <= SHORT_PREAMBLE ? SFD : PREAMBLE;
          end
        end
        PREAMBLE: begin
          gmii_txd <= 8'h55;
          if (step == PRE_LAST) begin
            state <= SFD;
            step  <= 16'd0;
          end else begin
            step <= step + 16'd1;
          end
        end
        SFD: begin
          gmii_txd <= 8'hD5;
          state    <= DATA;
        end
        DATA: begin
          step <= 16'd0;
          if (tx_valid) begin
            gmii_txd <= tx_data;
            crc      <= crc_upd;
            count    <= count_inc;
            if (tx_last) begin
              state <= (count_inc < MIN_COUNT) ? PAD : FCS;
            end
          end else begin
            // Source starved: close the frame with a deliberately bad FCS.
            gmii_txd    <= 8'h00;
            tx_underrun <= 1'b1;
            bad         <= 1'b1;
            state       <= FCS;
          end
        end
        PAD: begin
          gmii_txd <= 8'h00;
          crc      <= crc_upd;
          count    <= count_inc;
          if (count_inc >= MIN_COUNT) begin
            state <= FCS;
          end
        end
        FCS: begin
          gmii_txd <= fcs_byte;
          if (step == 16'd3) begin
            state <= IPG;
            step  <= 16'd0;
          end else begin
            step <= step + 16'd1;
          end
        end
        IPG: begin
          gmii_txen  <= 1'b0;
          gmii_txd   <= 8'h00;
          frame_done <= (step == 16'd0);
          if (step == IPG_LAST) begin
            state <= IDLE;
            step  <= 16'd0;
          end else begin
            step <= step + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed/randomized bench for gmii_tx_framer with a table-driven CRC
// reference model and a wire-level byte capture.
module tb_gmii_tx_framer;

  localparam int PRE = 7;

  logic       gmii_txc = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic       txen0, txen1;
  logic [7:0] txd0, txd1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic       ur0, ur1;
  logic       sel;   // 0: unpadded instance, 1: default instance

  always #4 gmii_txc = ~gmii_txc;

  gmii_tx_framer #(.MIN_FRAME(0), .IPG_BYTES(12), .PREAMBLE_BYTES(PRE)) u_nopad (
    .gmii_txc(gmii_txc), .reset(reset), .tx_data(tx_data), .tx_valid(valid0),
    .tx_last(tx_last), .tx_ready(ready0), .gmii_txen(txen0), .gmii_txd(txd0),
    .busy(busy0), .frame_done(done0), .tx_underrun(ur0));

  gmii_tx_framer u_dut (
    .gmii_txc(gmii_txc), .reset(reset), .tx_data(tx_data), .tx_valid(valid1),
    .tx_last(tx_last), .tx_ready(ready1), .gmii_txen(txen1), .gmii_txd(txd1),
    .busy(busy1), .frame_done(done1), .tx_underrun(ur1));

  logic       cur_txen, cur_busy, cur_done, cur_ur, cur_ready;
  logic [7:0] cur_txd;
  assign cur_txen  = sel ? txen1  : txen0;
  assign cur_txd   = sel ? txd1   : txd0;
  assign cur_busy  = sel ? busy1  : busy0;
  assign cur_done  = sel ? done1  : done0;
  assign cur_ur    = sel ? ur1    : ur0;
  assign cur_ready = sel ? ready1 : ready0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  data_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  cap_q[$];
  logic [31:0] crc_tab[256];

  int   txen_cycles, done_cnt, ur_cnt, seg_cnt, gap_run, last_gap, ipg_busy;
  logic txen_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wire monitor for the selected instance.
  always @(negedge gmii_txc) begin
    if (!reset) begin
      if (cur_txen) begin
        cap_q.push_back(cur_txd);
        txen_cycles++;
        if (!txen_prev) begin
          seg_cnt++;
          last_gap = gap_run;
          gap_run  = 0;
        end
        ipg_busy = 0;
      end else begin
        gap_run++;
        if (cur_busy) ipg_busy++;
      end
      if (cur_done) done_cnt++;
      if (cur_ur) ur_cnt++;
      txen_prev = cur_txen;
    end
  end

  task automatic clr_mon();
    @(posedge gmii_txc);
    cap_q.delete();
    exp_q.delete();
    txen_cycles = 0; done_cnt = 0; ur_cnt = 0; seg_cnt = 0;
    gap_run = 0; last_gap = 0; ipg_busy = 0; txen_prev = 1'b0;
  endtask

  task automatic set_valid(input logic v);
    if (sel) valid1 = v; else valid0 = v;
  endtask

  task automatic build_tab();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
  endtask

  task automatic fill_random(input int len);
    data_q.delete();
    for (int i = 0; i < len; i++) data_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Expected wire image: preamble, SFD, body (+pad), [underrun zero], FCS.
  task automatic model_frame(input int base, input int n_acc, input bit ur,
                             input int minf, output logic [31:0] fcs_o);
    logic [7:0]  body[$];
    logic [31:0] c;
    for (int i = 0; i < n_acc; i++) body.push_back(data_q[base + i]);
    if (!ur) while (body.size() < minf) body.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (body[i]) c = crc_tab[c[7:0] ^ body[i]] ^ (c >> 8);
    fcs_o = ~c;
    if (ur) fcs_o = fcs_o ^ 32'hFFFFFFFF;
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) exp_q.push_back(body[i]);
    if (ur) exp_q.push_back(8'h00);
    for (int k = 0; k < 4; k++) exp_q.push_back(fcs_o[8*k +: 8]);
  endtask

  // Source driver: hands over stop_at bytes of a len-byte frame.
  task automatic send_frame(input int base, input int len, input int stop_at, input bit hold);
    int   i;
    int   guard;
    logic rdy;
    i = 0;
    guard = 0;
    while (i < stop_at && guard < 4000) begin
      @(negedge gmii_txc);
      tx_data = data_q[base + i];
      tx_last = (i == len - 1);
      set_valid(1'b1);
      rdy = cur_ready;
      @(posedge gmii_txc);
      if (rdy) i++;
      guard++;
    end
    chk("bytes_accepted", 64'(i), 64'(stop_at));
    if (!hold) begin
      @(negedge gmii_txc);
      set_valid(1'b0);
      tx_last = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge gmii_txc);
      n++;
    end while ((cur_busy || cur_txen) && n < 5000);
    if (n >= 5000) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_idle_timeout observed=busy expected=idle", tag);
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp_fcs, input int exp_txen,
                             input int exp_done, input int exp_ur);
    int          bad_bytes;
    int          n;
    logic [31:0] cap_fcs;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    bad_bytes = 0;
    for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) bad_bytes++;
    chk({tag, "_len"}, 64'(cap_q.size()), 64'(exp_q.size()));
    chk({tag, "_bad_bytes"}, 64'(bad_bytes), 64'd0);
    chk({tag, "_txen_cycles"}, 64'(txen_cycles), 64'(exp_txen));
    chk({tag, "_frame_done"}, 64'(done_cnt), 64'(exp_done));
    chk({tag, "_underrun"}, 64'(ur_cnt), 64'(exp_ur));
    cap_fcs = 32'h0;
    if (cap_q.size() >= 4) begin
      n = cap_q.size();
      cap_fcs = {cap_q[n-1], cap_q[n-2], cap_q[n-3], cap_q[n-4]};
      chk({tag, "_fcs"}, 64'(cap_fcs), 64'(exp_fcs));
    end
    $display("frame %s: bytes=%0d txen_cycles=%0d fcs=%08h done=%0d underrun=%0d",
             tag, cap_q.size(), txen_cycles, cap_fcs, done_cnt, ur_cnt);
  endtask

  initial begin
    logic [31:0] fcs_a, fcs_b;
    string       s;
    reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0; tx_data = 8'h00; tx_last = 1'b0; sel = 1'b1;
    build_tab();

    // Reset state
    repeat (3) @(negedge gmii_txc);
    chk("rst_txen", 64'(txen1), 64'd0);
    chk("rst_txd", 64'(txd1), 64'd0);
    chk("rst_ready", 64'(ready1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_underrun", 64'(ur1), 64'd0);
    chk("rst_txen_nopad", 64'(txen0), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge gmii_txc);
    chk("idle_busy", 64'(busy1), 64'd0);
    chk("idle_ready", 64'(ready1), 64'd0);

    // "123456789" on the unpadded instance: well-known CRC check value
    sel = 1'b0;
    s = "123456789";
    data_q.delete();
    for (int i = 0; i < 9; i++) data_q.push_back(s[i]);
    clr_mon();
    send_frame(0, 9, 9, 1'b0);
    wait_idle("check_string");
    model_frame(0, 9, 1'b0, 0, fcs_a);
    check_frame("check_string", fcs_a, 21, 1, 0);
    chk("check_string_fcs_const",
        64'({cap_q[cap_q.size()-1], cap_q[cap_q.size()-2], cap_q[cap_q.size()-3], cap_q[cap_q.size()-4]}),
        64'h00000000CBF43926);

    // Short frame padded to 60 bytes
    sel = 1'b1;
    fill_random(14);
    clr_mon();
    send_frame(0, 14, 14, 1'b0);
    wait_idle("pad14");
    model_frame(0, 14, 1'b0, 60, fcs_a);
    check_frame("pad14", fcs_a, 72, 1, 0);

    // Two 64-byte frames with tx_valid held high across the gap
    fill_random(128);
    clr_mon();
    send_frame(0, 64, 64, 1'b1);
    send_frame(64, 64, 64, 1'b0);
    wait_idle("b2b");
    model_frame(0, 64, 1'b0, 60, fcs_a);
    model_frame(64, 64, 1'b0, 60, fcs_b);
    check_frame("b2b", fcs_b, 152, 2, 0);
    chk("b2b_gap", 64'(last_gap), 64'd13);
    chk("b2b_segments", 64'(seg_cnt), 64'd2);

    // Underrun after 10 of 20 bytes
    fill_random(20);
    clr_mon();
    send_frame(0, 20, 10, 1'b0);
    wait_idle("underrun");
    model_frame(0, 10, 1'b1, 60, fcs_a);
    check_frame("underrun", fcs_a, 23, 1, 1);

    // Reset while payload byte 30 is on the wire, then a clean frame
    fill_random(60);
    clr_mon();
    send_frame(0, 60, 30, 1'b1);
    #2;
    chk("abort_txen_before", 64'(txen1), 64'd1);
    reset = 1'b1;
    set_valid(1'b0);
    tx_last = 1'b0;
    #1;
    chk("abort_txen", 64'(txen1), 64'd0);
    chk("abort_busy", 64'(busy1), 64'd0);
    chk("abort_ready", 64'(ready1), 64'd0);
    @(negedge gmii_txc);
    reset = 1'b0;
    repeat (20) @(negedge gmii_txc);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_txen_idle", 64'(txen1), 64'd0);
    fill_random(20);
    clr_mon();
    send_frame(0, 20, 20, 1'b0);
    wait_idle("after_abort");
    model_frame(0, 20, 1'b0, 60, fcs_a);
    check_frame("after_abort", fcs_a, 72, 1, 0);

    // Maximum-size frame, no padding
    fill_random(1514);
    clr_mon();
    send_frame(0, 1514, 1514, 1'b0);
    wait_idle("max1514");
    model_frame(0, 1514, 1'b0, 60, fcs_a);
    check_frame("max1514", fcs_a, 1526, 1, 0);
    chk("max1514_ipg_busy", 64'(ipg_busy), 64'd12);
    chk("max1514_busy_end", 64'(busy1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- MAC transmit framer directly upstream of the GMII/RGMII conversion wrapper.
- Accepts a byte stream with valid/ready/last handshake and drives gmii_txen/gmii_txd.
- Wraps each frame with preamble and SFD, pads short frames, appends the CRC-32 FCS, and enforces the inter-packet gap.
- Runs on the GMII transmit clock, 1 byte per cycle (1000 Mbps).

Parameters:
MIN_FRAME, 60, minimum bytes before FCS (header+payload+pad); 0 disables padding
IPG_BYTES, 12, minimum idle cycles with gmii_txen low between frames
PREAMBLE_BYTES, 7, number of 0x55 bytes before SFD

Ports:
gmii_txc  input  1  GMII transmit clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
tx_data  input  8  frame byte (dst MAC first), excludes preamble/SFD/FCS
tx_valid  input  1  tx_data valid
tx_last  input  1  marks final byte of frame, qualified by tx_valid
tx_ready  output  1  framer accepts byte this cycle when tx_valid&tx_ready
gmii_txen  output  1  to GMII converter transmit enable
gmii_txd  output  8  to GMII converter transmit data
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse in the cycle after last FCS byte leaves gmii_txd
tx_underrun  output  1  one-cycle pulse when source starves mid-frame

Behaviour:
- Clock gmii_txc; reset asynchronous, active-high. Reset values: gmii_txen=0, gmii_txd=0x00, tx_ready=0, busy=0, frame_done=0, tx_underrun=0, state=IDLE, counters=0, crc=0xFFFFFFFF.
- gmii_txen/gmii_txd are registered; tx_ready is combinational from state (high only in DATA).
- FSM: IDLE -> PREAMBLE -> SFD -> DATA -> PAD -> FCS -> IPG -> IDLE.
  - IDLE: when tx_valid=1, go to PREAMBLE. The first 0x55 appears on gmii_txd with gmii_txen=1 on the next edge (1-cycle latency). tx_data is not consumed.
  - PREAMBLE: emit PREAMBLE_BYTES x 0x55, then SFD emits 0xD5.
  - DATA: tx_ready=1. The first accepted byte appears on gmii_txd in the cycle immediately after 0xD5; there is no bubble.
    - Each accepted byte updates the CRC and increments the 11-bit byte counter, which saturates at 2047.
    - On an accepted byte with tx_last=1: go to PAD if count < MIN_FRAME, else go to FCS.
  - PAD: emit 0x00 and update CRC until count = MIN_FRAME.
  - FCS: emit 4 bytes, ~crc, least significant byte first.
  - IPG: gmii_txen=0 and gmii_txd=0x00 for exactly IPG_BYTES cycles, then IDLE. A frame whose tx_valid is already high leaves IDLE next cycle, giving a gap of IPG_BYTES+1 cycles. tx_ready stays 0 throughout IPG.
- gmii_txen is high contiguously from the first preamble byte to the last FCS byte.
- CRC-32 (IEEE 802.3): reflected polynomial 0xEDB88320, LSB-first per byte, init 0xFFFFFFFF, covers data+pad only, final complement. 8-bit-parallel update in one cycle.
- Underrun: in DATA with tx_valid=0:
  - emit 0x00 that cycle;
  - pulse tx_underrun;
  - go to FCS with the transmitted FCS = correct FCS XOR 0xFFFFFFFF, so the frame is guaranteed bad;
  - no padding;
  - remaining source bytes up to tx_last are not consumed by the framer; the source must flush them itself.
- tx_last with an empty frame is not possible: the first DATA byte may carry tx_last.
- Reset mid-frame: gmii_txen drops asynchronously to 0 and the FSM returns to IDLE. No frame_done is issued.

Test Plan:
- MIN_FRAME=0, send ASCII "123456789" (tx_last on '9') -> gmii_txd: 7x55, D5, 31..39, then FCS 26 39 F4 CB; gmii_txen high for 21 cycles; frame_done pulses once.
- Default params, 14-byte frame -> 14 data bytes + 46 x 0x00, FCS matching the reference CRC model; gmii_txen high 72 cycles.
- Two 64-byte frames with tx_valid held high -> exactly 13 cycles with gmii_txen=0 between the last FCS byte and the next 0x55.
- 20-byte frame with tx_valid dropped after byte 10 -> tx_underrun pulse, 10 data + 0x00 + 4 FCS bytes equal to the model FCS XOR FFFFFFFF; gmii_txen high 23 cycles.
- reset asserted during payload byte 30 -> gmii_txen=0 immediately, busy=0, tx_ready=0; a following frame is transmitted correctly.
- 1514-byte frame with random data -> no padding; FCS matches model; busy low after IPG.
